// File: rtl/hazard_stall_gen.sv
// Pipeline stall/flush generator: load-use interlock, multi-cycle execute hold,
// data-memory wait with sticky timeout, and a saturating stall-cycle counter.
module hazard_stall_gen #(
  parameter int MC_LATENCY = 4,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_rs1_used,
  input  logic             dec_rs2_used,
  input  logic             exe_valid,
  input  logic [4:0]       exe_rd,
  input  logic             exe_is_load,
  input  logic             exe_mc_start,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MC_BUSY   = 2'd1,
    LOAD_WAIT = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [7:0] MC_LOAD  = 8'(MC_LATENCY - 1);
  localparam logic [7:0] WAIT_END = 8'(MAX_WAIT - 1);

  state_t     state;
  logic [7:0] mc_cnt;
  logic [7:0] wait_cnt;
  logic       load_hazard;
  logic       stall_raw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign load_hazard = dec_valid & exe_valid & exe_is_load & (exe_rd != 5'd0) &
                       ((dec_rs1_used & (dec_rs1 == exe_rd)) |
                        (dec_rs2_used & (dec_rs2 == exe_rd)));

  always_comb begin
    stall_raw = 1'b0;
    case (state)
      IDLE:      stall_raw = load_hazard | exe_mc_start;
      MC_BUSY:   stall_raw = 1'b1;
      LOAD_WAIT: stall_raw = ~mem_ready;
      FLUSH:     stall_raw = 1'b0;
      default:   stall_raw = 1'b0;
    endcase
  end

  // Gating with reset keeps the request low while the core is held in reset.
  assign stall = stall_raw & reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mc_cnt      <= 8'd0;
      wait_cnt    <= 8'd0;
      flush       <= 1'b0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      flush <= 1'b0;
      if (stall) stall_count <= sat_inc(stall_count);
      case (state)
        IDLE: begin
          // A taken branch squashes a multi-cycle op starting in the same cycle.
          if (branch_taken) begin
            state <= FLUSH;
            flush <= 1'b1;
          end else if (exe_mc_start) begin
            state  <= MC_BUSY;
            mc_cnt <= MC_LOAD;
          end else if (load_hazard) begin
            state    <= LOAD_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MC_BUSY: begin
          if (mc_cnt == 8'd0) state <= IDLE;
          else                mc_cnt <= mc_cnt - 8'd1;
        end
        LOAD_WAIT: begin
          if (mem_ready) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_END) begin
            state       <= IDLE;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_gen.sv
// Directed bench for hazard_stall_gen: load-use, x0/unused sources, multi-cycle,
// branch flush, memory timeout, async reset and counter saturation.
module tb_hazard_stall_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_valid, dec_rs1_used, dec_rs2_used;
  logic [4:0]  dec_rs1, dec_rs2, exe_rd;
  logic        exe_valid, exe_is_load, exe_mc_start, mem_ready, branch_taken;
  logic        stall, flush, mem_timeout;
  logic [15:0] stall_count;
  logic        stall_s, flush_s, mem_timeout_s;
  logic [1:0]  stall_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  hazard_stall_gen #(.MC_LATENCY(4), .MAX_WAIT(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_mc_start(exe_mc_start), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  hazard_stall_gen #(.MC_LATENCY(4), .MAX_WAIT(16), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_is_load(exe_is_load),
    .exe_mc_start(exe_mc_start), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .stall(stall_s), .flush(flush_s), .mem_timeout(mem_timeout_s), .stall_count(stall_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    exe_valid = 0; exe_rd = 0; exe_is_load = 0; exe_mc_start = 0;
    mem_ready = 0; branch_taken = 0;
  endtask

  task automatic set_hazard(input logic [4:0] rd);
    dec_valid = 1; dec_rs1 = rd; dec_rs1_used = 1; dec_rs2 = 5'd1; dec_rs2_used = 1;
    exe_valid = 1; exe_rd = rd; exe_is_load = 1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    #12;
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_count", stall_count, 0);
    set_hazard(5'd5);
    #1 check("rst_stall_gated", stall, 0);
    idle_inputs();
    @(negedge clock) reset = 1;
    tick();

    // load-use: lw x5 in exe, add x6,x5,x1 in decode
    set_hazard(5'd5);
    #1 check("lu_c0_stall", stall, 1);
    tick();
    exe_valid = 0; exe_is_load = 0; mem_ready = 0;
    #1 check("lu_c1_stall", stall, 1);
    tick();
    mem_ready = 1;
    #1 check("lu_c2_stall", stall, 0);
    tick();
    idle_inputs();
    #1 check("lu_idle_stall", stall, 0);
    check("lu_count", stall_count, 2);

    // x0 target and unused source never interlock
    dec_valid = 1; dec_rs1 = 0; dec_rs1_used = 1;
    exe_valid = 1; exe_is_load = 1; exe_rd = 0;
    #1 check("x0_stall", stall, 0);
    tick();
    dec_rs1 = 5'd3; dec_rs2 = 5'd7; dec_rs2_used = 0; exe_rd = 5'd7;
    #1 check("unused_stall", stall, 0);
    tick();
    dec_rs2_used = 1;
    #1 check("rs2_stall", stall, 1);
    tick();
    idle_inputs(); mem_ready = 1;
    #1 check("rs2_ready_stall", stall, 0);
    tick();
    idle_inputs();
    check("rs2_count", stall_count, 3);

    // multi-cycle op: MC_LATENCY+1 stall cycles, branch mid-burst ignored
    exe_mc_start = 1;
    #1 check("mc_start_stall", stall, 1);
    tick();
    exe_mc_start = 0;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 1);
      #1 check($sformatf("mc_busy%0d_stall", i), stall, 1);
      check($sformatf("mc_busy%0d_flush", i), flush, 0);
      tick();
    end
    branch_taken = 0;
    #1 check("mc_end_stall", stall, 0);
    check("mc_end_flush", flush, 0);
    tick();
    check("mc_after_flush", flush, 0);
    check("mc_count", stall_count, 8);
    check("sat_count", stall_count_s, 3);

    // branch in IDLE: one-cycle flush, no stall; branch during FLUSH ignored
    branch_taken = 1;
    #1 check("br_stall", stall, 0);
    check("br_flush0", flush, 0);
    tick();
    branch_taken = 1;
    #1 check("br_flush1", flush, 1);
    check("br_flush_stall", stall, 0);
    tick();
    branch_taken = 0;
    check("br_flush2", flush, 0);
    tick();
    check("br_flush3", flush, 0);

    // branch + mc_start together: branch wins, single stall cycle
    branch_taken = 1; exe_mc_start = 1;
    #1 check("brmc_stall", stall, 1);
    tick();
    idle_inputs();
    #1 check("brmc_flush", flush, 1);
    check("brmc_stall1", stall, 0);
    tick();
    check("brmc_flush_end", flush, 0);
    check("brmc_stall2", stall, 0);
    check("brmc_count", stall_count, 9);

    // timeout: hazard cycle + MAX_WAIT wait cycles, then sticky mem_timeout
    set_hazard(5'd9);
    #1 check("to_c0_stall", stall, 1);
    tick();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      #1 check($sformatf("to_w%0d_stall", i), stall, 1);
      check($sformatf("to_w%0d_flag", i), mem_timeout, 0);
      tick();
    end
    check("to_end_stall", stall, 0);
    check("to_flag", mem_timeout, 1);
    check("to_count", stall_count, 26);
    tick();
    check("to_flag_sticky", mem_timeout, 1);
    check("to_idle_stall", stall, 0);

    // async reset in the middle of MC_BUSY
    exe_mc_start = 1;
    tick();
    exe_mc_start = 0;
    tick();
    #1 check("rmc_busy_stall", stall, 1);
    #1 reset = 0;
    #1 check("rmc_stall", stall, 0);
    check("rmc_flush", flush, 0);
    check("rmc_count", stall_count, 0);
    check("rmc_timeout", mem_timeout, 0);
    @(negedge clock) reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rmc_post%0d_stall", i), stall, 0);
      check($sformatf("rmc_post%0d_flush", i), flush, 0);
    end
    check("rmc_post_count", stall_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
